sigma_delta_dac: RTL and testbench



---
 rtl/sigma_delta_dac.sv | 110 +++++++++++
 tb/tb_sigma_delta_dac.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta (PDM) 1-bit DAC with a one-entry sample buffer.
// Each accepted sample is held for OSR modulator ticks; the pin feeds an RC filter.
module sigma_delta_dac #(
    parameter int DATA_WIDTH = 12,
    parameter int CLK_DIV    = 1,
    parameter int OSR        = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_sample,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_digital,
    output logic                  o_frame,
    output logic                  o_underrun
);
    localparam int W     = DATA_WIDTH;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OSR_W = $clog2(OSR);

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [OSR_W-1:0] OSR_MAX = OSR_W'(OSR - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [OSR_W-1:0] osr_cnt_q, osr_cnt_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [W-1:0]     active_q, active_d;
    logic [W-1:0]     pending_q, pending_d;
    logic             pending_full_q, pending_full_d;
    logic             digital_q, digital_d;
    logic             frame_q, frame_d;
    logic             underrun_q, underrun_d;

    logic             tick;
    logic             boundary;
    logic             handshake;
    logic [W-1:0]     u;
    logic [W:0]       sum;

    always_comb begin
        tick      = (div_cnt_q == DIV_MAX);
        boundary  = tick && (osr_cnt_q == OSR_MAX);
        handshake = i_valid && !pending_full_q;
        // Offset binary: midscale signed 0 maps to 2^(W-1).
        u   = {~active_q[W-1], active_q[W-2:0]};
        sum = {1'b0, acc_q} + {1'b0, u};

        div_cnt_d      = tick ? '0 : div_cnt_q + DIV_W'(1);
        osr_cnt_d      = osr_cnt_q;
        acc_d          = acc_q;
        digital_d      = digital_q;
        active_d       = active_q;
        pending_d      = pending_q;
        pending_full_d = pending_full_q;
        frame_d        = 1'b0;
        underrun_d     = 1'b0;

        if (tick) begin
            osr_cnt_d = (osr_cnt_q == OSR_MAX) ? '0 : osr_cnt_q + OSR_W'(1);
            acc_d     = sum[W-1:0];
            digital_d = sum[W];
        end

        if (boundary) begin
            frame_d = 1'b1;
            if (pending_full_q) begin
                active_d       = pending_q;
                pending_full_d = 1'b0;
            end else begin
                underrun_d = 1'b1;
            end
        end

        // Only possible while empty, so it never collides with a load.
        if (handshake) begin
            pending_d      = i_sample;
            pending_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            div_cnt_q      <= '0;
            osr_cnt_q      <= '0;
            acc_q          <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            pending_full_q <= 1'b0;
            digital_q      <= 1'b0;
            frame_q        <= 1'b0;
            underrun_q     <= 1'b0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            osr_cnt_q      <= osr_cnt_d;
            acc_q          <= acc_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            pending_full_q <= pending_full_d;
            digital_q      <= digital_d;
            frame_q        <= frame_d;
            underrun_q     <= underrun_d;
        end
    end

    assign o_ready    = ~pending_full_q;
    assign o_digital  = digital_q;
    assign o_frame    = frame_q;
    assign o_underrun = underrun_q;

endmodule

// File: tb/tb_sigma_delta_dac.sv
// Bench for sigma_delta_dac: four configurations driven in lockstep
// against a cumulative-sum pulse-density model.
module tb_sigma_delta_dac;
    localparam int N = 4;

    logic          clk;
    logic          rst;
    logic          valid;
    logic [11:0]   sample;
    logic [N-1:0]  rdy, dig, frm, und;

    int checks = 0;
    int errors = 0;

    longint m_cyc [N];
    longint m_cum [N];
    int     m_act [N];
    int     m_pend [N];
    logic   m_full [N];
    logic   m_dig [N];
    logic   m_frm [N];
    logic   m_und [N];

    int ones [N];
    int frames [N];
    int unders [N];

    typedef struct {
        logic        r;
        logic        v;
        logic [11:0] s;
        logic        dig;
        logic        rdy;
        logic        frm;
    } vec_t;

    sigma_delta_dac #(.DATA_WIDTH(12), .CLK_DIV(1), .OSR(256)) u_a (
        .i_clk(clk), .i_rst(rst), .i_sample(sample), .i_valid(valid),
        .o_ready(rdy[0]), .o_digital(dig[0]), .o_frame(frm[0]), .o_underrun(und[0])
    );
    sigma_delta_dac #(.DATA_WIDTH(12), .CLK_DIV(4), .OSR(256)) u_b (
        .i_clk(clk), .i_rst(rst), .i_sample(sample), .i_valid(valid),
        .o_ready(rdy[1]), .o_digital(dig[1]), .o_frame(frm[1]), .o_underrun(und[1])
    );
    sigma_delta_dac #(.DATA_WIDTH(12), .CLK_DIV(1), .OSR(4096)) u_c (
        .i_clk(clk), .i_rst(rst), .i_sample(sample), .i_valid(valid),
        .o_ready(rdy[2]), .o_digital(dig[2]), .o_frame(frm[2]), .o_underrun(und[2])
    );
    sigma_delta_dac #(.DATA_WIDTH(6), .CLK_DIV(3), .OSR(5)) u_d (
        .i_clk(clk), .i_rst(rst), .i_sample(sample[5:0]), .i_valid(valid),
        .o_ready(rdy[3]), .o_digital(dig[3]), .o_frame(frm[3]), .o_underrun(und[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic int wd(input int i);
        return (i == 3) ? 6 : 12;
    endfunction
    function automatic int cd(input int i);
        return (i == 1) ? 4 : (i == 3) ? 3 : 1;
    endfunction
    function automatic int os(input int i);
        return (i == 2) ? 4096 : (i == 3) ? 5 : 256;
    endfunction

    function automatic int sx(input logic [11:0] s, input int w);
        int v;
        v = int'(s) & ((1 << w) - 1);
        if (v >= (1 << (w - 1))) v -= (1 << w);
        return v;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0b want %0b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Output bit = carry of the running total of u across a 2^W boundary.
    task automatic model(input int i, input logic r, input logic v, input logic [11:0] s);
        logic   hs;
        longint old;
        m_frm[i] = 1'b0;
        m_und[i] = 1'b0;
        if (r) begin
            m_cyc[i]  = 0;
            m_cum[i]  = 0;
            m_act[i]  = 0;
            m_full[i] = 1'b0;
            m_dig[i]  = 1'b0;
            return;
        end
        hs = v && !m_full[i];
        m_cyc[i]++;
        if (m_cyc[i] % cd(i) == 0) begin
            old = m_cum[i];
            m_cum[i] += longint'(m_act[i] + (1 << (wd(i) - 1)));
            m_dig[i] = ((m_cum[i] >> wd(i)) != (old >> wd(i)));
            if ((m_cyc[i] / cd(i)) % os(i) == 0) begin
                m_frm[i] = 1'b1;
                if (m_full[i]) begin
                    m_act[i]  = m_pend[i];
                    m_full[i] = 1'b0;
                end else begin
                    m_und[i] = 1'b1;
                end
            end
        end
        if (hs) begin
            m_pend[i] = sx(s, wd(i));
            m_full[i] = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [11:0] s);
        rst = r;
        valid = v;
        sample = s;
        for (int i = 0; i < N; i++) model(i, r, v, s);
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("dut%0d_digital", i), dig[i], m_dig[i]);
            chk($sformatf("dut%0d_frame", i), frm[i], m_frm[i]);
            chk($sformatf("dut%0d_underrun", i), und[i], m_und[i]);
            chk($sformatf("dut%0d_ready", i), rdy[i], !m_full[i]);
            ones[i]   += int'(dig[i]);
            frames[i] += int'(frm[i]);
            unders[i] += int'(und[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 12'h000);
    endtask

    task automatic clr();
        for (int i = 0; i < N; i++) begin
            ones[i] = 0;
            frames[i] = 0;
            unders[i] = 0;
        end
    endtask

    initial begin
        vec_t        tbl [8];
        logic [11:0] bp [3];
        int          acc_edge [3];
        int          idx;
        int          fr_ones [4];
        int          early_under;
        logic        go;
        logic        r;
        int          p;

        tbl[0] = '{1'b1, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 12'h000, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 12'h400, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 12'h123, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        valid = 1'b0;
        sample = '0;

        for (int k = 0; k < 8; k++) begin
            step(tbl[k].r, tbl[k].v, tbl[k].s);
            chk($sformatf("tbl%0d_digital", k), dig[0], tbl[k].dig);
            chk($sformatf("tbl%0d_ready", k), rdy[0], tbl[k].rdy);
            chk($sformatf("tbl%0d_frame", k), frm[0], tbl[k].frm);
        end

        // Midscale idle: underrun every frame.
        step(1'b1, 1'b0, 12'h000);
        clr();
        idle(512);
        chk_int("idle_frames_a", frames[0], 2);
        chk_int("idle_unders_a", unders[0], 2);
        chk_int("idle_ones_a", ones[0], 256);
        chk_int("idle_frames_b", frames[1], 0);

        // +1024 -> 3/4 density, on both CLK_DIV=1 and CLK_DIV=4.
        step(1'b1, 1'b0, 12'h000);
        step(1'b0, 1'b1, 12'h400);
        idle(255);
        clr();
        idle(256);
        chk_int("q3_ones_a", ones[0], 192);
        idle(512);
        clr();
        idle(1024);
        chk_int("q3_ones_b", ones[1], 768);
        chk_int("q3_frames_b", frames[1], 1);

        // -2048 -> all zeros.
        step(1'b1, 1'b0, 12'h000);
        step(1'b0, 1'b1, 12'h800);
        idle(255);
        clr();
        idle(256);
        chk_int("min_ones_a", ones[0], 0);

        // +2047 over a 4096-tick frame -> 4095 ones.
        step(1'b1, 1'b0, 12'h000);
        step(1'b0, 1'b1, 12'h7FF);
        idle(4095);
        clr();
        idle(4096);
        chk_int("max_ones_c", ones[2], 4095);

        // Backpressure with valid held high.
        bp[0] = 12'h400;
        bp[1] = 12'hC00;
        bp[2] = 12'h000;
        for (int k = 0; k < 3; k++) acc_edge[k] = -1;
        for (int k = 0; k < 4; k++) fr_ones[k] = 0;
        early_under = 0;
        idx = 0;
        step(1'b1, 1'b0, 12'h000);
        for (int c = 1; c <= 1024; c++) begin
            go = (idx < 3);
            if (go && rdy[0]) acc_edge[idx] = c;
            step(1'b0, go, go ? bp[idx] : 12'h000);
            if (go && acc_edge[idx] == c) idx++;
            fr_ones[(c - 1) / 256] += int'(dig[0]);
            if (c <= 768) early_under += int'(und[0]);
        end
        chk_int("bp_accept_a", acc_edge[0], 1);
        chk_int("bp_accept_b", acc_edge[1], 257);
        chk_int("bp_accept_c", acc_edge[2], 513);
        chk_int("bp_no_underrun", early_under, 0);
        chk_int("bp_frame0_ones", fr_ones[0], 128);
        chk_int("bp_frame1_ones", fr_ones[1], 192);
        chk_int("bp_frame2_ones", fr_ones[2], 64);
        chk_int("bp_frame3_ones", fr_ones[3], 128);

        // Reset mid-frame with a pending sample and acc nonzero.
        step(1'b1, 1'b0, 12'h000);
        step(1'b0, 1'b1, 12'h400);
        idle(101);
        step(1'b1, 1'b0, 12'h000);
        chk("rst_ready", rdy[0], 1'b1);
        chk("rst_digital", dig[0], 1'b0);
        chk("rst_frame", frm[0], 1'b0);
        chk("rst_underrun", und[0], 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b0, 12'h000);
            chk($sformatf("rst_pat%0d", k), dig[0], (k % 2) == 1);
        end
        clr();
        idle(300);
        chk_int("rst_frames_a", frames[0], 1);
        chk_int("rst_dropped_a", unders[0], 1);

        // Random traffic: sparse then dense input, rare resets.
        step(1'b1, 1'b0, 12'h000);
        for (int c = 0; c < 4000; c++) begin
            r = ($urandom_range(0, 1999) == 0);
            p = (c < 2000) ? 300 : 6;
            step(r, $urandom_range(0, p - 1) == 0, 12'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
